lookahead_seq_subtractor: RTL and testbench



---
 rtl/lookahead_seq_subtractor.sv | 210 +++++++++++++++++++++
 tb/tb_lookahead_seq_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lookahead_seq_subtractor.sv
// ---------------------------------------------------------------------------
// lookahead_seq_subtractor
//
// Purpose:
//   Multi-cycle wide subtractor. Computes F = A - B - Bin (modulo 2^W,
//   W = B_W*N_CH). It processes one B_W-bit chunk per clock, least-significant
//   chunk first. Each chunk is a borrow-lookahead group: generate/propagate
//   are formed on A and ~B, and the group carry-in is ~borrow. A registered
//   borrow links consecutive chunks.
//
// Optional feature (macro SUB_SAT_EN):
//   When defined, a signed overflow replaces F with the signed extreme that
//   matches the sign of A (0x80..0 for negative A, 0x7F..F otherwise). V
//   still reports 1, Bo is unchanged, and Z is evaluated on the saturated F.
//   When undefined, F is the raw modulo-2^W difference.
//
// Handshake:
//   start is sampled only in IDLE. When start is accepted at edge k, the
//   block latches A, B and Bin. busy is high for the N_CH RUN cycles. done is
//   a one-cycle pulse in the cycle after edge k+N_CH. F, Bo, V and Z are valid
//   from that cycle and hold until the next accepted start. start is ignored
//   during RUN and DONE.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   start        in   request (sampled in IDLE only)
//   A            in   W   minuend
//   B            in   W   subtrahend
//   Bin          in   borrow-in
//   busy         out  high during RUN
//   done         out  one-cycle completion pulse
//   F            out  W   difference
//   Bo           out  borrow-out (unsigned A < B + Bin)
//   V            out  signed overflow
//   Z            out  final F == 0
//   o_dbg_state  out  2   current FSM state (IDLE=0, RUN=1, DONE=2)
// ---------------------------------------------------------------------------
module lookahead_seq_subtractor #(
   parameter int B_W  = 4,
   parameter int N_CH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [B_W*N_CH-1:0] A,
   input  logic [B_W*N_CH-1:0] B,
   input  logic                Bin,
   output logic                busy,
   output logic                done,
   output logic [B_W*N_CH-1:0] F,
   output logic                Bo,
   output logic                V,
   output logic                Z,
   output logic [1:0]          o_dbg_state
);

   localparam int W     = B_W * N_CH;
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic               r_borrow;
   logic [IDX_W-1:0]   r_idx;
   logic [W-1:0]       r_f;
   logic               r_bo;
   logic               r_v;
   logic               r_z;

   logic [B_W-1:0]     w_ca;       // current chunk of A
   logic [B_W-1:0]     w_cb_n;     // current chunk of ~B
   logic [B_W-1:0]     w_g;
   logic [B_W-1:0]     w_p;
   logic [B_W:0]       w_c;        // lookahead carries; w_c[B_W] is carry-out
   logic               w_pp;       // running propagate product
   logic [B_W-1:0]     w_sum;
   logic               w_last;
   logic [W-1:0]       w_f_raw;
   logic [W-1:0]       w_f_fin;
   logic               w_v;
   logic               w_z;

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   assign w_last = (r_idx == IDX_W'(N_CH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign o_dbg_state = r_state;

   // -------------------------------------------------------------------------
   // Chunk borrow-lookahead. Subtraction is a + ~b + ~borrow. Each carry is
   // expanded as a sum of products over the group (g_i | p_i g_{i-1} | ...
   // | p_i..p_0 c0) instead of a ripple chain.
   // -------------------------------------------------------------------------
   always_comb begin
      w_ca   = r_a[r_idx*B_W +: B_W];
      w_cb_n = ~r_b[r_idx*B_W +: B_W];
      w_g    = w_ca & w_cb_n;
      w_p    = w_ca | w_cb_n;
      w_c    = '0;
      w_pp   = 1'b0;
      w_c[0] = ~r_borrow;
      for (int i = 0; i < B_W; i++) begin
         w_c[i+1] = w_g[i];
         w_pp     = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_c[i+1] = w_c[i+1] | (w_pp & w_g[j]);
            w_pp     = w_pp & w_p[j];
         end
         w_c[i+1] = w_c[i+1] | (w_pp & w_c[0]);
      end
      w_sum = w_ca ^ w_cb_n ^ w_c[B_W-1:0];
   end

   // Full result as it will look once the last chunk lands. The flags are
   // only consumed on the final RUN edge.
   always_comb begin
      w_f_raw                         = r_f;
      w_f_raw[(N_CH-1)*B_W +: B_W]    = w_sum;
      w_v = (r_a[W-1] != r_b[W-1]) & (w_f_raw[W-1] != r_a[W-1]);
`ifdef SUB_SAT_EN
      if (w_v) begin
         w_f_fin = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         w_f_fin = w_f_raw;
      end
`else
      w_f_fin = w_f_raw;
`endif
      w_z = (w_f_fin == '0);
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_idx    <= '0;
         r_f      <= '0;
         r_bo     <= 1'b0;
         r_v      <= 1'b0;
         r_z      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= Bin;
                  r_idx    <= '0;
               end
            end
            S_RUN: begin
               r_borrow <= ~w_c[B_W];
               if (w_last) begin
                  // Final chunk: commit the whole result and the flags at once.
                  r_idx <= '0;
                  r_f   <= w_f_fin;
                  r_bo  <= ~w_c[B_W];
                  r_v   <= w_v;
                  r_z   <= w_z;
               end else begin
                  r_idx                  <= r_idx + IDX_W'(1);
                  r_f[r_idx*B_W +: B_W]  <= w_sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign F  = r_f;
   assign Bo = r_bo;
   assign V  = r_v;
   assign Z  = r_z;

endmodule

// File: tb/tb_lookahead_seq_subtractor.sv
// ---------------------------------------------------------------------------
// Bench for lookahead_seq_subtractor. It runs directed vectors against a
// plain-arithmetic model and a scoreboard queue, with literal pins on the
// model. It also covers the control cases: start ignored in RUN and DONE,
// reset in mid-RUN, and restart.
// ---------------------------------------------------------------------------
module tb_lookahead_seq_subtractor;

   localparam int B_W  = 4;
   localparam int N_CH = 4;
   localparam int W    = B_W * N_CH;
   localparam int RW   = W + 3;   // {F, Bo, V, Z}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          Bin = 1'b0;
   logic          busy, done, Bo, V, Z;
   logic [W-1:0]  F;
   logic [1:0]    dbg_state;

   lookahead_seq_subtractor #(.B_W(B_W), .N_CH(N_CH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .Bin         (Bin),
      .busy        (busy),
      .done        (done),
      .F           (F),
      .Bo          (Bo),
      .V           (V),
      .Z           (Z),
      .o_dbg_state (dbg_state)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [RW-1:0] exp_q[$];

   // ---------------- model ----------------
   function automatic logic [RW-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic bin);
      longint d, sd, smax, smin;
      logic [W-1:0] f;
      logic bo, v, z;
      d    = longint'(a) - longint'(b) - longint'(bin);
      bo   = (d < 0);
      f    = d[W-1:0];
      sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      v    = (sd > smax) || (sd < smin);
`ifdef SUB_SAT_EN
      if (v) f = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      z    = (f == '0);
      return {f, bo, v, z};
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act,
                        input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got F=%h Bo=%b V=%b Z=%b, want F=%h Bo=%b V=%b Z=%b",
                  name, act[RW-1:3], act[2], act[1], act[0],
                  exp[RW-1:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   // ---------------- scoreboard compare process ----------------
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 with no pending op, want 0");
         end else begin
            check("result", {F, Bo, V, Z}, exp_q.pop_front());
            check_bit("busy_in_done", busy, 1'b0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input bit noisy);
      int cyc;
      logic [RW-1:0] e;
      e = model(a, b, bin);
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(negedge clk);            // acceptance edge has passed
      start = 1'b0;
      exp_q.push_back(e);
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      cyc = 0;
      while (done !== 1'b1 && cyc < N_CH + 5) begin
         check_bit("busy_run", busy, 1'b1);
         start = (noisy && cyc == 1);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      n_cmp++;
      if (cyc != N_CH) begin
         n_err++;
         $display("FAIL latency: got %0d cycles to done, want %0d", cyc, N_CH);
      end
      if (noisy) start = 1'b1;   // sampled on the edge leaving DONE
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_bit("idle_busy", busy, 1'b0);
         check_bit("idle_done", done, 1'b0);
         check("hold", {F, Bo, V, Z}, e);
         @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Literal pins on the model itself.
      check("pin_1234", model(16'h1234, 16'h0234, 1'b0), {16'h1000, 3'b000});
      check("pin_0m1",  model(16'h0000, 16'h0001, 1'b0), {16'hFFFF, 3'b100});
      check("pin_eqbin", model(16'hABCD, 16'hABCD, 1'b1), {16'hFFFF, 3'b100});
      check("pin_zero", model(16'h5555, 16'h5554, 1'b1), {16'h0000, 3'b001});
`ifdef SUB_SAT_EN
      check("pin_negov", model(16'h8000, 16'h0001, 1'b0), {16'h8000, 3'b010});
      check("pin_posov", model(16'h7FFF, 16'hFFFF, 1'b0), {16'h7FFF, 3'b110});
`else
      check("pin_negov", model(16'h8000, 16'h0001, 1'b0), {16'h7FFF, 3'b010});
      check("pin_posov", model(16'h7FFF, 16'hFFFF, 1'b0), {16'h8000, 3'b110});
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_out", {F, Bo, V, Z}, '0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);

      // Directed vectors.
      run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
      run_op(16'h5555, 16'h5554, 1'b1, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      run_op(16'h8000, 16'h0000, 1'b1, 1'b0);
      run_op(16'hF0F0, 16'h0F0F, 1'b0, 1'b1);   // start pulses in RUN and DONE
      run_op(16'h0000, 16'h0001, 1'b0, 1'b0);   // leaves F and Bo non-zero

      // Reset during the 2nd RUN cycle.
      @(negedge clk);
      A = 16'h9876; B = 16'h1234; Bin = 1'b0; start = 1'b1;
      @(negedge clk);            // after the acceptance edge: RUN cycle 1
      start = 1'b0;
      @(negedge clk);            // RUN cycle 2
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_reset_out", {F, Bo, V, Z}, '0);
      check_bit("midrun_reset_busy", busy, 1'b0);
      check_bit("midrun_reset_done", done, 1'b0);
      for (int i = 0; i < N_CH + 3; i++) begin
         @(negedge clk);
         check_bit("no_done_after_reset", done, 1'b0);
      end

      // Restart after reset.
      run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_ops: got %0d left in queue, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
